// File: rtl/voice_mixer_pdm.sv
// Voice mixer: gated voice popcount per sample tick, soft-mute volume ramp, first-order sigma-delta PDM out.
// Optional build macro MIX_LFSR_DITHER_EN adds a 16-bit Galois LFSR carry-in dither to the accumulator.
module voice_mixer_pdm #(
  parameter int VOICES   = 7,
  parameter int SMPL_DIV = 64,
  parameter int VOL_BW   = 4
) (
  input  logic                               clk_i,
  input  logic                               nrst_i,
  input  logic [VOICES-1:0]                  wave_i,
  input  logic [VOICES-1:0]                  active_i,
  input  logic                               mute_i,
  output logic [$clog2(VOICES+1)-1:0]        sample_o,
  output logic                               sampleStrb_o,
  output logic [VOL_BW-1:0]                  vol_o,
  output logic                               pdm_o
);

  localparam int SUM_BW = $clog2(VOICES+1);
  localparam int SC_BW  = $clog2(VOICES*(2**VOL_BW-1)+1);
  localparam int CNT_BW = $clog2(SMPL_DIV);
  localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(SMPL_DIV-1);
  localparam logic [CNT_BW-1:0] CNT_ONE  = CNT_BW'(1);
  localparam logic [VOL_BW-1:0] VOL_MAX  = '1;
  localparam logic [VOL_BW-1:0] VOL_ONE  = VOL_BW'(1);

  typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DOWN} state_e;

  logic [CNT_BW-1:0] tickCnt_q, tickCnt_d;
  logic              tick;
  logic [SUM_BW-1:0] sample_q, popCnt;
  logic              strb_q;
  state_e            state_q, state_d;
  logic [VOL_BW-1:0] vol_q, vol_d;
  logic              go;
  logic [SUM_BW+VOL_BW-1:0] prod;
  logic [SC_BW-1:0]  scaled;
  logic [SC_BW-1:0]  acc_q;
  logic [SC_BW:0]    accSum_d;
  logic              pdm_q;
  logic              carryIn;

  assign tick      = (tickCnt_q == CNT_LAST);
  assign tickCnt_d = tick ? '0 : tickCnt_q + CNT_ONE;
  assign go        = !mute_i && (active_i != '0);

  always_comb begin
    popCnt = '0;
    for (int i = 0; i < VOICES; i++) begin
      popCnt = popCnt + SUM_BW'(wave_i[i] & active_i[i]);
    end
  end

  // Volume ramp: moves one step per tick, reversing direction immediately when go changes.
  always_comb begin
    state_d = state_q;
    vol_d   = vol_q;
    if (tick) begin
      case (state_q)
        MUTED: begin
          if (go) begin
            vol_d   = VOL_ONE;
            state_d = RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (!go) begin
            vol_d   = vol_q - VOL_ONE;
            state_d = (vol_q == VOL_ONE) ? MUTED : RAMP_DOWN;
          end else begin
            vol_d = vol_q + VOL_ONE;
            if (vol_q == VOL_MAX - VOL_ONE) state_d = PLAY;
          end
        end
        PLAY: begin
          if (!go) begin
            vol_d   = VOL_MAX - VOL_ONE;
            state_d = RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (go) begin
            vol_d   = vol_q + VOL_ONE;
            state_d = (vol_q == VOL_MAX - VOL_ONE) ? PLAY : RAMP_UP;
          end else if (vol_q <= VOL_ONE) begin
            vol_d   = '0;
            state_d = MUTED;
          end else begin
            vol_d = vol_q - VOL_ONE;
          end
        end
        default: begin
          vol_d   = '0;
          state_d = MUTED;
        end
      endcase
    end
  end

  assign prod   = sample_q * vol_q;
  assign scaled = SC_BW'(prod);

`ifdef MIX_LFSR_DITHER_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign carryIn = lfsr_q[0] & (scaled != '0);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign carryIn = 1'b0;
`endif

  assign accSum_d = {1'b0, acc_q} + {1'b0, scaled} + {{SC_BW{1'b0}}, carryIn};

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      tickCnt_q <= '0;
      sample_q  <= '0;
      strb_q    <= 1'b0;
      state_q   <= MUTED;
      vol_q     <= '0;
      acc_q     <= '0;
      pdm_q     <= 1'b0;
    end else begin
      tickCnt_q <= tickCnt_d;
      strb_q    <= tick;
      if (tick) sample_q <= popCnt;
      state_q   <= state_d;
      vol_q     <= vol_d;
      acc_q     <= accSum_d[SC_BW-1:0];
      pdm_q     <= accSum_d[SC_BW];
    end
  end

  assign sample_o     = sample_q;
  assign sampleStrb_o = strb_q;
  assign vol_o        = vol_q;
  assign pdm_o        = pdm_q;

endmodule

// File: tb/tb_voice_mixer_pdm.sv
// Self-checking bench for voice_mixer_pdm: tick-level vector table plus hand sequences
// for strobe timing, PDM density, mute silence and asynchronous reset.
module tb_voice_mixer_pdm;

  localparam int VOICES   = 7;
  localparam int SMPL_DIV = 64;
  localparam int VOL_BW   = 4;

  logic       clk;
  logic       nrst;
  logic [6:0] wave;
  logic [6:0] active;
  logic       mute;
  logic [2:0] sample;
  logic       sampleStrb;
  logic [3:0] vol;
  logic       pdm;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] wave;
    logic [6:0] active;
    logic       mute;
    int         expSample;
    int         expVol;
  } vec_t;

  vec_t vecs[$];

  voice_mixer_pdm #(
    .VOICES  (VOICES),
    .SMPL_DIV(SMPL_DIV),
    .VOL_BW  (VOL_BW)
  ) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .wave_i      (wave),
    .active_i    (active),
    .mute_i      (mute),
    .sample_o    (sample),
    .sampleStrb_o(sampleStrb),
    .vol_o       (vol),
    .pdm_o       (pdm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] w, input logic [6:0] a, input logic m);
    wave   = w;
    active = a;
    mute   = m;
  endtask

  task automatic waitStrobe();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sampleStrb && n < SMPL_DIV + 4);
    if (!sampleStrb) begin
      checks++;
      errors++;
      $display("[TB] FAIL strobe_timeout: got no strobe, expected one within %0d clocks", SMPL_DIV + 4);
    end
  endtask

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) waitStrobe();
  endtask

  task automatic countOnes(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ones += int'(pdm);
    end
  endtask

  initial begin
    int n;
    int ones;

    for (int v = 1; v <= 8; v++) vecs.push_back('{7'h7F, 7'h7F, 1'b0, 7, v});
    for (int v = 7; v >= 0; v--) vecs.push_back('{7'h7F, 7'h7F, 1'b1, 7, v});
    vecs.push_back('{7'h7F, 7'h7F, 1'b1, 7, 0});
    for (int v = 1; v <= 15; v++) vecs.push_back('{7'h7F, 7'h05, 1'b0, 2, v});
    vecs.push_back('{7'h7F, 7'h05, 1'b0, 2, 15});
    for (int v = 14; v >= 0; v--) vecs.push_back('{7'h7F, 7'h00, 1'b0, 0, v});
    vecs.push_back('{7'h7F, 7'h00, 1'b0, 0, 0});

    // Reset with arbitrary inputs; everything must read zero.
    nrst = 1'b0;
    applyStimulus(7'h55, 7'h2A, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("rst_sample", int'(sample), 0);
    checkOutput("rst_strobe", int'(sampleStrb), 0);
    checkOutput("rst_vol", int'(vol), 0);
    checkOutput("rst_pdm", int'(pdm), 0);

    // Release with mute held; measure strobe latency and period.
    applyStimulus(7'h7F, 7'h7F, 1'b1);
    nrst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sampleStrb && n < 200);
    checkOutput("first_strobe_latency", n, 64);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sampleStrb && n < 200);
    checkOutput("strobe_period", n, 64);
    @(negedge clk);
    checkOutput("strobe_width", int'(sampleStrb), 0);
    checkOutput("muted_vol", int'(vol), 0);

    // Tick-by-tick vector table: ramp up, mute reversal, gating, idle ramp down.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wave, vecs[i].active, vecs[i].mute);
      waitStrobe();
      checkOutput($sformatf("vec%0d_sample", i), int'(sample), vecs[i].expSample);
      checkOutput($sformatf("vec%0d_vol", i), int'(vol), vecs[i].expVol);
    end

    // Full mix to PLAY, then density 7*15 = 105 ones per 128 clocks.
    applyStimulus(7'h7F, 7'h7F, 1'b0);
    waitTicks(15);
    checkOutput("full_play_vol", int'(vol), 15);
    waitTicks(2);
    countOnes(128, ones);
    checkOutput("full_density", ones, 105);

    // Mute from PLAY: 15 ticks down to zero, then silence despite nonzero sample.
    applyStimulus(7'h7F, 7'h7F, 1'b1);
    waitTicks(15);
    checkOutput("mute_vol", int'(vol), 0);
    checkOutput("mute_sample", int'(sample), 7);
    waitTicks(1);
    countOnes(256, ones);
    checkOutput("mute_silence", ones, 0);

    // Gated mix: two voices at full volume gives 30 ones per 128 clocks.
    applyStimulus(7'h7F, 7'h05, 1'b0);
    waitTicks(15);
    checkOutput("gated_vol", int'(vol), 15);
    checkOutput("gated_sample", int'(sample), 2);
    waitTicks(2);
    countOnes(128, ones);
    checkOutput("gated_density", ones, 30);

    // Asynchronous reset mid-cycle while playing.
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    checkOutput("async_rst_sample", int'(sample), 0);
    checkOutput("async_rst_vol", int'(vol), 0);
    checkOutput("async_rst_strobe", int'(sampleStrb), 0);
    checkOutput("async_rst_pdm", int'(pdm), 0);
    repeat (3) @(negedge clk);
    applyStimulus(7'h7F, 7'h7F, 1'b0);
    nrst = 1'b1;
    waitStrobe();
    checkOutput("restart_vol", int'(vol), 1);
    checkOutput("restart_sample", int'(sample), 7);
    waitStrobe();
    checkOutput("restart_vol2", int'(vol), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
